// File: rtl/alu_uart_pkg.sv
// alu_uart_pkg: definitions shared by the host and the ALU-side UART interface.
//   - host_state_e : host sequencer state encoding
//   - IDX_*        : order in which the command bytes travel on the UART
//   - OP_*         : ALU opcode values
package alu_uart_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSendA   = 3'd1,
        StSendB   = 3'd2,
        StSendOp  = 3'd3,
        StWaitRes = 3'd4,
        StDone    = 3'd5
    } host_state_e;

    localparam int unsigned IDX_A  = 0;
    localparam int unsigned IDX_B  = 1;
    localparam int unsigned IDX_OP = 2;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/alu_uart_timeout_cnt.sv
// alu_uart_timeout_cnt: cycle counter bounding the wait for a result byte.
//   clock   : system clock
//   reset   : synchronous active-high reset
//   clear   : restart the count from zero
//   enable  : count this cycle
//   expired : high on the enabled cycle that completes TIMEOUT counted cycles
module alu_uart_timeout_cnt #(
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] Last = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] count_q;

    assign expired = enable && (count_q == Last);

    // Holds at Last once reached so the count can never wrap.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_uart_host.sv
// alu_uart_host: sends one ALU command (A, B, opcode) as three UART bytes and waits for the
// one-byte result, with a cycle timeout.
//   clock, i_reset          : clock and synchronous active-high reset
//   i_start, i_a, i_b, i_op : command request and operands (sampled in idle only)
//   i_tx_full, o_w_data, o_wr_uart  : transmit FIFO push side
//   i_rx_empty, i_r_data, o_rd_uart : receive FIFO pop side
//   o_busy, o_done, o_timeout, o_result : status and last result
module alu_uart_host
    import alu_uart_pkg::*;
#(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned NB_OP   = 6,
    parameter int unsigned NB_AB   = 8,
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [NB_AB-1:0] i_a,
    input  logic [NB_AB-1:0] i_b,
    input  logic [NB_OP-1:0] i_op,
    input  logic             i_tx_full,
    output logic [DBIT-1:0]  o_w_data,
    output logic             o_wr_uart,
    input  logic             i_rx_empty,
    input  logic [DBIT-1:0]  i_r_data,
    output logic             o_rd_uart,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout,
    output logic [NB_AB-1:0] o_result
);

    host_state_e state_q, state_d;

    logic [NB_AB-1:0] a_q, b_q, result_q;
    logic [NB_OP-1:0] op_q;
    logic             timeout_q, timeout_d;
    logic             capture, take_result;
    logic             cnt_clear, cnt_en, expired;
    logic [DBIT-1:0]  cmd_bytes [3];

    assign cmd_bytes[IDX_A]  = DBIT'(a_q);
    assign cmd_bytes[IDX_B]  = DBIT'(b_q);
    assign cmd_bytes[IDX_OP] = DBIT'(op_q);

    // Counter restarts on the opcode push and only runs on waiting cycles without a pop,
    // so a byte arriving on the expiry cycle still wins.
    assign cnt_clear = (state_q == StSendOp) && !i_tx_full;
    assign cnt_en    = (state_q == StWaitRes) && i_rx_empty;

    alu_uart_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clock   (clock),
        .reset   (i_reset),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        timeout_d   = timeout_q;
        capture     = 1'b0;
        take_result = 1'b0;
        o_wr_uart   = 1'b0;
        o_rd_uart   = 1'b0;
        o_w_data    = '0;
        unique case (state_q)
            StIdle: begin
                // Stale bytes are drained and dropped while idle.
                o_rd_uart = !i_rx_empty;
                if (i_start) begin
                    capture = 1'b1;
                    state_d = StSendA;
                end
            end
            StSendA: begin
                o_w_data  = cmd_bytes[IDX_A];
                o_wr_uart = !i_tx_full;
                if (!i_tx_full) state_d = StSendB;
            end
            StSendB: begin
                o_w_data  = cmd_bytes[IDX_B];
                o_wr_uart = !i_tx_full;
                if (!i_tx_full) state_d = StSendOp;
            end
            StSendOp: begin
                o_w_data  = cmd_bytes[IDX_OP];
                o_wr_uart = !i_tx_full;
                if (!i_tx_full) state_d = StWaitRes;
            end
            StWaitRes: begin
                o_rd_uart = !i_rx_empty;
                if (!i_rx_empty) begin
                    take_result = 1'b1;
                    timeout_d   = 1'b0;
                    state_d     = StDone;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;
            if (capture) begin
                a_q  <= i_a;
                b_q  <= i_b;
                op_q <= i_op;
            end
            if (take_result) begin
                result_q <= i_r_data[NB_AB-1:0];
            end
        end
    end

    assign o_busy    = (state_q != StIdle);
    assign o_done    = (state_q == StDone);
    assign o_timeout = (state_q == StDone) && timeout_q;
    assign o_result  = result_q;

endmodule
